// File: rtl/pb_event_if.sv
// Valid/ready event stream carrying debounced button events to the game FSM.
interface pb_event_if #(
    parameter int N_BTN = 4
);
    localparam int ID_W = (N_BTN > 1) ? $clog2(N_BTN) : 1;

    logic            evt_valid;
    logic            evt_ready;
    logic [ID_W-1:0] evt_id;
    logic            evt_repeat;

    modport master (output evt_valid, evt_id, evt_repeat, input evt_ready);
    modport slave  (input evt_valid, evt_id, evt_repeat, output evt_ready);
endinterface

// File: rtl/pb_event_arbiter.sv
// Push-button front end: tick-sampled debounce, press/auto-repeat detection and
// round-robin arbitration of pending button events onto one valid/ready stream.
module pb_event_arbiter #(
    parameter int N_BTN      = 4,
    parameter int DB_LEN     = 4,
    parameter int TICK_DIV   = 16,
    parameter int REPEAT_DLY = 32,
    parameter int REPEAT_PER = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] pb,
    output logic [N_BTN-1:0] pb_level,
    output logic             drop_pulse,
    pb_event_if.master       evt
);
    localparam int ID_W   = (N_BTN > 1) ? $clog2(N_BTN) : 1;
    localparam int IDX_W  = ID_W + 1;
    localparam int DIV_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int HOLD_W = $clog2(REPEAT_DLY + 1);

    logic [DIV_W-1:0] div_reg;
    logic             tick;

    assign tick = (div_reg == DIV_W'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    div_reg <= '0;
        else if (tick) div_reg <= '0;
        else           div_reg <= div_reg + 1'b1;
    end

    logic [N_BTN-1:0] req_set;
    logic [N_BTN-1:0] req_rep;

    generate
        for (genvar gi = 0; gi < N_BTN; gi++) begin : g_btn
            logic [DB_LEN-1:0] sh_reg;
            logic [DB_LEN-1:0] sh_next;
            logic              level_reg;
            logic              level_d_reg;
            logic [HOLD_W-1:0] hold_reg;
            logic              press;
            logic              rep_fire;

            assign sh_next  = (sh_reg << 1) | DB_LEN'(pb[gi]);
            assign press    = level_reg & ~level_d_reg;
            assign rep_fire = tick & level_reg & ~press &
                              (hold_reg == HOLD_W'(REPEAT_DLY - 1));

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sh_reg    <= '0;
                    level_reg <= 1'b0;
                end else if (tick) begin
                    sh_reg <= sh_next;
                    // Hysteresis: only a full run of identical samples moves the level
                    if (&sh_next)       level_reg <= 1'b1;
                    else if (~|sh_next) level_reg <= 1'b0;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    level_d_reg <= 1'b0;
                    hold_reg    <= '0;
                end else begin
                    level_d_reg <= level_reg;
                    if (!level_reg || press) hold_reg <= '0;
                    else if (rep_fire)       hold_reg <= HOLD_W'(REPEAT_DLY - REPEAT_PER);
                    else if (tick)           hold_reg <= hold_reg + 1'b1;
                end
            end

            assign pb_level[gi] = level_reg;
            assign req_set[gi]  = press | rep_fire;
            assign req_rep[gi]  = rep_fire;
        end
    endgenerate

    function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] v);
        return (int'(v) == N_BTN - 1) ? '0 : v + 1'b1;
    endfunction

    logic [N_BTN-1:0] pend_reg, pend_next;
    logic [N_BTN-1:0] rep_reg, rep_next;
    logic [N_BTN-1:0] acc_vec, cand, merge;
    logic [ID_W-1:0]  rr_reg, rr_next, id_reg, id_next, base, sel_id;
    logic             valid_reg, valid_next, erep_reg, erep_next;
    logic             accept, sel_found;

    assign accept = valid_reg & evt.evt_ready;
    assign base   = accept ? wrap_inc(id_reg) : rr_reg;
    // The presented button is masked so an accept never re-presents it at once
    assign cand   = pend_reg & ~acc_vec;

    always_comb begin
        acc_vec = '0;
        if (accept) acc_vec[id_reg] = 1'b1;
    end

    always_comb begin
        logic [IDX_W-1:0] js;
        sel_found = 1'b0;
        sel_id    = '0;
        js        = '0;
        for (int k = 0; k < N_BTN; k++) begin
            js = {1'b0, base} + IDX_W'(k);
            if (js >= IDX_W'(N_BTN)) js = js - IDX_W'(N_BTN);
            if (!sel_found && cand[js[ID_W-1:0]]) begin
                sel_found = 1'b1;
                sel_id    = js[ID_W-1:0];
            end
        end
    end

    always_comb begin
        pend_next  = pend_reg;
        rep_next   = rep_reg;
        merge      = '0;
        valid_next = valid_reg;
        id_next    = id_reg;
        erep_next  = erep_reg;
        rr_next    = rr_reg;
        for (int i = 0; i < N_BTN; i++) begin
            if (req_set[i] && (!pend_reg[i] || acc_vec[i])) begin
                pend_next[i] = 1'b1;
                rep_next[i]  = req_rep[i];
            end else if (req_set[i]) begin
                merge[i] = 1'b1;
            end else if (acc_vec[i]) begin
                pend_next[i] = 1'b0;
            end
        end
        if (accept) rr_next = wrap_inc(id_reg);
        if (!valid_reg || accept) begin
            valid_next = sel_found;
            if (sel_found) begin
                id_next   = sel_id;
                erep_next = rep_reg[sel_id];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_reg  <= '0;
            rep_reg   <= '0;
            rr_reg    <= '0;
            id_reg    <= '0;
            erep_reg  <= 1'b0;
            valid_reg <= 1'b0;
        end else begin
            pend_reg  <= pend_next;
            rep_reg   <= rep_next;
            rr_reg    <= rr_next;
            id_reg    <= id_next;
            erep_reg  <= erep_next;
            valid_reg <= valid_next;
        end
    end

    assign drop_pulse     = |merge;
    assign evt.evt_valid  = valid_reg;
    assign evt.evt_id     = id_reg;
    assign evt.evt_repeat = erep_reg;
endmodule
